// File: rtl/synapse_scheduler.sv
// Presynaptic spike scheduler: edge-detects per-channel spikes, delays each by a
// programmable count, and serialises the results onto one output via round-robin.
module synapse_scheduler #(
    parameter int NUM_PRE       = 4,
    parameter int DELAY_W       = 3,
    parameter int DEFAULT_DELAY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PRE-1:0]         spike_in,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_PRE)-1:0] cfg_addr,
    input  logic [DELAY_W-1:0]         cfg_delay,
    input  logic                       ovf_clr,
    output logic                       spike_out,
    output logic [$clog2(NUM_PRE)-1:0] spike_src,
    output logic                       busy,
    output logic                       overflow
);
    localparam int AW = $clog2(NUM_PRE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PEND  = 2'd2
    } ch_state_e;

    // state_q is the per-channel FSM state, kept as a named array for probing
    ch_state_e          state_q [NUM_PRE];
    ch_state_e          state_d [NUM_PRE];
    logic [DELAY_W-1:0] cnt_q   [NUM_PRE];
    logic [DELAY_W-1:0] cnt_d   [NUM_PRE];
    logic [DELAY_W-1:0] delay_q [NUM_PRE];

    logic [NUM_PRE-1:0] prev_q;
    logic [NUM_PRE-1:0] rise;
    logic [NUM_PRE-1:0] pend;
    logic [NUM_PRE-1:0] active;
    logic [AW-1:0]      last_grant_q;
    logic [AW-1:0]      grant_idx;
    logic [AW-1:0]      cand;
    logic               grant_vld;
    logic               drop;

    assign rise = spike_in & ~prev_q;
    assign busy = |active;
    assign drop = |(rise & active);

    always_comb begin
        pend   = '0;
        active = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            pend[i]   = (state_q[i] == ST_PEND);
            active[i] = (state_q[i] != ST_IDLE);
        end
    end

    // Scan from farthest to nearest so the first pending channel after last_grant wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_grant_q;
        cand      = last_grant_q;
        for (int i = NUM_PRE; i >= 1; i--) begin
            cand = last_grant_q + AW'(i);
            if (pend[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PRE; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        if (delay_q[i] == '0) begin
                            state_d[i] = ST_PEND;
                        end else begin
                            state_d[i] = ST_DELAY;
                            cnt_d[i]   = delay_q[i];
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q[i] <= DELAY_W'(1)) begin
                        state_d[i] = ST_PEND;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - DELAY_W'(1);
                    end
                end
                ST_PEND: begin
                    if (grant_vld && (grant_idx == AW'(i))) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PRE; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
                delay_q[i] <= DELAY_W'(DEFAULT_DELAY);
            end
            prev_q       <= '0;
            last_grant_q <= AW'(NUM_PRE - 1);
            spike_out    <= 1'b0;
            spike_src    <= '0;
            overflow     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PRE; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            // Rises on this edge already latched their delay above, so a write here is seen only later
            if (cfg_we) begin
                delay_q[cfg_addr] <= cfg_delay;
            end
            prev_q    <= spike_in;
            spike_out <= grant_vld;
            if (grant_vld) begin
                spike_src    <= grant_idx;
                last_grant_q <= grant_idx;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_synapse_scheduler.sv
// Directed bench for synapse_scheduler: expected (edge, source) pairs are queued by
// the driver and matched by a negedge monitor against every spike_out pulse.
module tb_synapse_scheduler;
    localparam int NUM_PRE = 4;
    localparam int DELAY_W = 3;
    localparam int AW      = 2;
    localparam int W       = 16 + AW;

    logic               clk;
    logic               rst_n;
    logic [NUM_PRE-1:0] spike_in;
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [DELAY_W-1:0] cfg_delay;
    logic               ovf_clr;
    logic               spike_out;
    logic [AW-1:0]      spike_src;
    logic               busy;
    logic               overflow;

    int          checks;
    int          errors;
    int          edge_cnt;
    int          k;
    int          e0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    synapse_scheduler #(
        .NUM_PRE(NUM_PRE),
        .DELAY_W(DELAY_W),
        .DEFAULT_DELAY(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spike_in(spike_in),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_delay(cfg_delay),
        .ovf_clr(ovf_clr),
        .spike_out(spike_out),
        .spike_src(spike_src),
        .busy(busy),
        .overflow(overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // monitor: every spike_out cycle must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && spike_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_spike: got src=%0d at edge %0d, expected no spike", spike_src, edge_cnt);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({16'(edge_cnt), spike_src} !== mon_exp) begin
                    errors++;
                    $display("FAIL spike_match: got src=%0d edge=%0d, expected src=%0d edge=%0d",
                             spike_src, edge_cnt, mon_exp[AW-1:0], mon_exp[W-1:AW]);
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_spike(input int src, input int at_edge);
        exp_q.push_back({16'(at_edge), AW'(src)});
    endtask

    task automatic cfg_write(input logic [AW-1:0] ch, input logic [DELAY_W-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = ch;
        cfg_delay = d;
        tick(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse(input logic [NUM_PRE-1:0] mask);
        spike_in = mask;
        tick(1);
        spike_in = '0;
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d spikes still outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        spike_in  = '0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_delay = '0;
        ovf_clr   = 1'b0;
        tick(3);
        check("rst_spike_out", 32'(spike_out), 0);
        check("rst_spike_src", 32'(spike_src), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        tick(1);

        // default delay of 1
        k = edge_cnt + 1; expect_spike(0, k + 2); pulse(4'b0001); drain();

        // delay 3 latency, busy while in flight
        cfg_write(2, 3);
        k = edge_cnt + 1; expect_spike(2, k + 4); pulse(4'b0100);
        check("busy_in_flight", 32'(busy), 1);
        drain();
        check("busy_after", 32'(busy), 0);

        // zero delay
        cfg_write(0, 0);
        k = edge_cnt + 1; expect_spike(0, k + 1); pulse(4'b0001); drain();

        // ch3 alone leaves last_grant at 3
        k = edge_cnt + 1; expect_spike(3, k + 2); pulse(4'b1000); drain();

        // contention on 0,1,3 all delay 1
        cfg_write(0, 1);
        k = edge_cnt + 1;
        expect_spike(0, k + 2); expect_spike(1, k + 3); expect_spike(3, k + 4);
        pulse(4'b1011); drain();
        check("contention_ovf", 32'(overflow), 0);

        // fairness: channels 0 and 1 re-arm as soon as they return to IDLE
        cfg_write(0, 0);
        cfg_write(1, 0);
        e0 = edge_cnt + 1;
        for (int j = 1; j <= 20; j++) expect_spike((j % 2 == 1) ? 0 : 1, e0 + j);
        spike_in = 4'b0011; tick(1);
        spike_in = 4'b0000; tick(1);
        for (int j = 2; j <= 19; j++) begin
            spike_in = (j % 2 == 0) ? 4'b0001 : 4'b0010;
            tick(1);
        end
        spike_in = '0;
        drain();
        check("fairness_ovf", 32'(overflow), 0);

        // round-robin wrap: last_grant=1 so search starts at 2
        cfg_write(0, 1); cfg_write(1, 1); cfg_write(2, 1);
        k = edge_cnt + 1;
        expect_spike(2, k + 2); expect_spike(0, k + 3); expect_spike(1, k + 4);
        pulse(4'b0111); drain();

        // write and rise on the same edge: old delay 1, then new delay 7
        k = edge_cnt + 1; expect_spike(2, k + 2);
        cfg_we = 1'b1; cfg_addr = 2; cfg_delay = 7; spike_in = 4'b0100;
        tick(1);
        cfg_we = 1'b0; spike_in = '0;
        drain();
        k = edge_cnt + 1; expect_spike(2, k + 8); pulse(4'b0100); drain();

        // drop while in DELAY, sticky overflow, clear
        cfg_write(1, 5);
        k = edge_cnt + 1; expect_spike(1, k + 6);
        pulse(4'b0010); tick(1); pulse(4'b0010);
        check("drop_ovf_set", 32'(overflow), 1);
        drain();
        check("drop_ovf_sticky", 32'(overflow), 1);
        clear_ovf();
        check("drop_ovf_clr", 32'(overflow), 0);

        // clear and drop on the same edge: set wins
        k = edge_cnt + 1; expect_spike(1, k + 6);
        pulse(4'b0010); tick(1);
        spike_in = 4'b0010; ovf_clr = 1'b1;
        tick(1);
        spike_in = '0; ovf_clr = 1'b0;
        check("set_wins_ovf", 32'(overflow), 1);
        drain();
        clear_ovf();
        check("set_wins_clr", 32'(overflow), 0);

        // rise on the edge where the channel is granted is dropped
        k = edge_cnt + 1; expect_spike(3, k + 2);
        pulse(4'b1000); tick(1); pulse(4'b1000);
        check("grant_edge_ovf", 32'(overflow), 1);
        drain();

        // reset mid-operation: ch2 just granted, ch3 pending, overflow set
        cfg_write(2, 1);
        pulse(4'b1100);
        tick(1);
        check("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        spike_in = 4'b0001;
        #1;
        check("mid_rst_spike_out", 32'(spike_out), 0);
        check("mid_rst_spike_src", 32'(spike_src), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_overflow", 32'(overflow), 0);
        tick(2);
        rst_n = 1'b1;
        // spike_in held high across release counts as a rise on the first edge
        k = edge_cnt + 1; expect_spike(0, k + 2);
        tick(1);
        spike_in = '0;
        drain();
        // delay registers are back at the default of 1
        k = edge_cnt + 1; expect_spike(2, k + 2); pulse(4'b0100); drain();
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
